vram_scan_arbiter: RTL and testbench

Owns the single VRAM port between the VGA timing generator and game-logic writers (background/tile loader). It converts the timing generator's scan position plus a frame-latched horizontal scroll offset into a VRAM read address, and returns the fetched pixel. During blanking it grants the port to a write requester. It replaces free-running address increment with a scroll-aware, wrap-around address computation.

---
 rtl/vram_scan_arbiter_pkg.sv | 9 +
 rtl/vram_addr_gen.sv | 18 +
 rtl/vram_scan_arbiter.sv | 87 ++++++++
 tb/tb_vram_scan_arbiter.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vram_scan_arbiter_pkg.sv
// vram_scan_arbiter_pkg: port-owner states and screen/image defaults
package vram_scan_arbiter_pkg;
  typedef enum logic [1:0] {S_IDLE, S_DISP, S_WR} owner_e;
  localparam int SCR_W = 640;
  localparam int SCR_H = 480;
  localparam int IMG_W_DEF = 1024;
  localparam int IMG_H_DEF = 480;
  localparam int PIX_W_DEF = 12;
endpackage

// File: rtl/vram_addr_gen.sv
// vram_addr_gen: scroll-aware, column-wrapping VRAM read address
module vram_addr_gen import vram_scan_arbiter_pkg::*; #(
  parameter int IMG_W = IMG_W_DEF,
  parameter int ADDR_W = 19
) (
  input  logic [9:0]        disp_x,
  input  logic [9:0]        disp_y,
  input  logic [9:0]        scroll_cur,
  output logic [ADDR_W-1:0] addr
);
  localparam int XW = $clog2(IMG_W);
  logic [10:0] col;
  // Row times image width is a shift; the 11-bit column sum wraps at the image edge
  always_comb begin
    col = ({1'b0, disp_x} + {1'b0, scroll_cur}) & 11'(IMG_W - 1);
    addr = (ADDR_W'(disp_y) << XW) + ADDR_W'(col);
  end
endmodule

// File: rtl/vram_scan_arbiter.sv
// vram_scan_arbiter: shares one VRAM port between scan-out reads and blanking writes
module vram_scan_arbiter import vram_scan_arbiter_pkg::*; #(
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF,
  parameter int ADDR_W = 19,
  parameter int PIX_W = PIX_W_DEF
) (
  input  logic              clk_25mhz,
  input  logic              Rst_n,
  input  logic              disp_pre,
  input  logic [9:0]        disp_x,
  input  logic [9:0]        disp_y,
  input  logic              vblank,
  input  logic [9:0]        scroll_in,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [PIX_W-1:0]  wr_data,
  output logic              wr_gnt,
  output logic [ADDR_W-1:0] vram_addr,
  output logic              vram_we,
  output logic [PIX_W-1:0]  vram_wdata,
  input  logic [PIX_W-1:0]  vram_rdata,
  output logic [PIX_W-1:0]  pix_rgb,
  output logic              pix_vld,
  output logic [9:0]        scroll_cur,
  output logic [15:0]       wr_stall_cnt
);
  localparam logic [9:0] SCROLL_MASK = 10'(IMG_W - 1);
  if (IMG_W * IMG_H > (1 << ADDR_W)) begin : g_size_check
    $error("vram_scan_arbiter: IMG_W*IMG_H exceeds the VRAM address space");
  end
  owner_e state, state_nxt;
  logic [ADDR_W-1:0] disp_addr, addr_nxt;
  logic vblank_q, rd_vld;
  vram_addr_gen #(.IMG_W(IMG_W), .ADDR_W(ADDR_W)) u_addr_gen (
    .disp_x(disp_x),
    .disp_y(disp_y),
    .scroll_cur(scroll_cur),
    .addr(disp_addr)
  );
  assign wr_gnt = wr_req && !disp_pre;
  assign vram_we = (state == S_WR);
  // Next owner and address: display always wins, idle keeps the last address
  always_comb begin
    state_nxt = disp_pre ? S_DISP : wr_req ? S_WR : S_IDLE;
    addr_nxt = disp_pre ? disp_addr : wr_req ? wr_addr : vram_addr;
  end
  // Owner state register and registered port command
  always_ff @(posedge clk_25mhz or negedge Rst_n) begin
    if (!Rst_n) begin
      state <= S_IDLE;
      vram_addr <= '0;
      vram_wdata <= '0;
    end else begin
      state <= state_nxt;
      vram_addr <= addr_nxt;
      if (wr_gnt) vram_wdata <= wr_data;
    end
  end
  // Read data arrives the cycle after a display access and is registered out
  always_ff @(posedge clk_25mhz or negedge Rst_n) begin
    if (!Rst_n) begin
      rd_vld <= 1'b0;
      pix_vld <= 1'b0;
      pix_rgb <= '0;
    end else begin
      rd_vld <= (state == S_DISP);
      pix_vld <= rd_vld;
      pix_rgb <= rd_vld ? vram_rdata : '0;
    end
  end
  // Scroll changes only on the vblank rising edge so a frame never tears
  always_ff @(posedge clk_25mhz or negedge Rst_n) begin
    if (!Rst_n) begin
      vblank_q <= 1'b0;
      scroll_cur <= '0;
    end else begin
      vblank_q <= vblank;
      if (vblank && !vblank_q) scroll_cur <= scroll_in & SCROLL_MASK;
    end
  end
  // Saturating count of cycles a writer waited on the display
  always_ff @(posedge clk_25mhz or negedge Rst_n) begin
    if (!Rst_n) wr_stall_cnt <= '0;
    else if (wr_req && !wr_gnt && wr_stall_cnt != 16'hFFFF) wr_stall_cnt <= wr_stall_cnt + 16'd1;
  end
endmodule

// File: tb/tb_vram_scan_arbiter.sv
// tb_vram_scan_arbiter: directed and randomized checks against a behavioural model
module tb_vram_scan_arbiter;
  localparam int AW = 19;
  localparam int PW = 12;
  logic clk_25mhz = 1'b0;
  logic Rst_n = 1'b1;
  logic disp_pre = 1'b0, vblank = 1'b0, wr_req = 1'b0;
  logic [9:0] disp_x = '0, disp_y = '0, scroll_in = '0;
  logic [AW-1:0] wr_addr = '0;
  logic [PW-1:0] wr_data = '0;
  logic wr_gnt, vram_we, pix_vld;
  logic [AW-1:0] vram_addr;
  logic [PW-1:0] vram_wdata, vram_rdata, pix_rgb;
  logic [9:0] scroll_cur;
  logic [15:0] wr_stall_cnt;
  int errors = 0;
  int checks = 0;
  logic [PW-1:0] mem [int];
  logic [PW-1:0] sh [int];

  vram_scan_arbiter dut (
    .clk_25mhz(clk_25mhz), .Rst_n(Rst_n), .disp_pre(disp_pre), .disp_x(disp_x),
    .disp_y(disp_y), .vblank(vblank), .scroll_in(scroll_in), .wr_req(wr_req),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt), .vram_addr(vram_addr),
    .vram_we(vram_we), .vram_wdata(vram_wdata), .vram_rdata(vram_rdata),
    .pix_rgb(pix_rgb), .pix_vld(pix_vld), .scroll_cur(scroll_cur), .wr_stall_cnt(wr_stall_cnt)
  );

  always #20 clk_25mhz = ~clk_25mhz;

  function automatic logic [PW-1:0] pat(int a);
    return PW'(a * 29 + (a >> 7) + 5);
  endfunction
  function automatic logic [PW-1:0] ram_rd(int a);
    return mem.exists(a) ? mem[a] : pat(a);
  endfunction
  function automatic logic [PW-1:0] sh_rd(int a);
    return sh.exists(a) ? sh[a] : pat(a);
  endfunction

  // Synchronous VRAM: one-cycle read latency, read-before-write
  always @(posedge clk_25mhz) begin
    vram_rdata <= ram_rd(int'(vram_addr));
    if (vram_we) mem[int'(vram_addr)] = vram_wdata;
  end

  task automatic drive(bit dp, int x, int y, bit vb, int sc, bit wr, int wa, int wd);
    disp_pre = dp; disp_x = 10'(x); disp_y = 10'(y); vblank = vb; scroll_in = 10'(sc);
    wr_req = wr; wr_addr = AW'(wa); wr_data = PW'(wd);
  endtask
  task automatic tick;
    @(negedge clk_25mhz);
  endtask
  task automatic idle;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic latch_scroll(int sc);
    idle; tick;
    drive(0, 0, 0, 1, sc, 0, 0, 0); tick;
    idle; tick;
  endtask

  task automatic test_reset;
    idle; tick;
    Rst_n = 1'b0; tick; tick;
    Rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick;
      checks++;
      if ({vram_addr, vram_we, vram_wdata, pix_rgb, pix_vld, scroll_cur, wr_stall_cnt, wr_gnt} !== '0) begin
        errors++;
        $display("FAIL reset_idle cyc%0d: addr=%0d we=%b wdata=%h pix=%h vld=%b scroll=%0d stall=%0d gnt=%b, need all 0",
                 i, vram_addr, vram_we, vram_wdata, pix_rgb, pix_vld, scroll_cur, wr_stall_cnt, wr_gnt);
      end
    end
  endtask

  task automatic test_scroll_read;
    latch_scroll(100);
    checks++;
    if (scroll_cur !== 10'd100) begin errors++; $display("FAIL scroll_latch: got %0d need 100", scroll_cur); end
    drive(1, 0, 1, 0, 0, 0, 0, 0); tick; idle;
    checks++;
    if (vram_addr !== AW'(1124) || vram_we !== 1'b0) begin
      errors++; $display("FAIL scroll_addr: addr=%0d we=%b need 1124/0", vram_addr, vram_we);
    end
    tick;
    checks++;
    if (pix_vld !== 1'b0) begin errors++; $display("FAIL scroll_early_vld: vld=%b need 0", pix_vld); end
    tick;
    checks++;
    if (pix_vld !== 1'b1 || pix_rgb !== pat(1124)) begin
      errors++; $display("FAIL scroll_pix: vld=%b rgb=%h need 1/%h", pix_vld, pix_rgb, pat(1124));
    end
    tick;
    checks++;
    if (pix_vld !== 1'b0 || pix_rgb !== '0) begin
      errors++; $display("FAIL pix_clear: vld=%b rgb=%h need 0/0", pix_vld, pix_rgb);
    end
  endtask

  task automatic test_wrap;
    latch_scroll(1000);
    drive(1, 30, 0, 0, 0, 0, 0, 0); tick; idle;
    checks++;
    if (vram_addr !== AW'(6)) begin errors++; $display("FAIL wrap_addr: addr=%0d need 6", vram_addr); end
    tick; tick;
    checks++;
    if (pix_vld !== 1'b1 || pix_rgb !== pat(6)) begin
      errors++; $display("FAIL wrap_pix: vld=%b rgb=%h need 1/%h", pix_vld, pix_rgb, pat(6));
    end
    drive(0, 0, 0, 0, 500, 0, 0, 0); tick; tick; tick;
    checks++;
    if (scroll_cur !== 10'd1000) begin errors++; $display("FAIL scroll_hold: got %0d need 1000", scroll_cur); end
    drive(1, 30, 0, 1, 200, 0, 0, 0); tick;
    checks++;
    if (vram_addr !== AW'(6)) begin errors++; $display("FAIL edge_same_cycle: addr=%0d need 6", vram_addr); end
    drive(1, 30, 0, 0, 0, 0, 0, 0); tick; idle;
    checks++;
    if (vram_addr !== AW'(230)) begin errors++; $display("FAIL edge_next_read: addr=%0d need 230", vram_addr); end
    tick; tick; tick;
  endtask

  task automatic test_write;
    drive(0, 0, 0, 0, 0, 1, 5, 12'hABC); #1;
    checks++;
    if (wr_gnt !== 1'b1) begin errors++; $display("FAIL write_gnt: gnt=%b need 1", wr_gnt); end
    tick; idle;
    checks++;
    if (vram_we !== 1'b1 || vram_addr !== AW'(5) || vram_wdata !== 12'hABC) begin
      errors++; $display("FAIL write_issue: we=%b addr=%0d data=%h need 1/5/abc", vram_we, vram_addr, vram_wdata);
    end
    #1;
    checks++;
    if (wr_gnt !== 1'b0) begin errors++; $display("FAIL write_nogrant: gnt=%b need 0", wr_gnt); end
    tick;
    checks++;
    if (vram_we !== 1'b0 || vram_addr !== AW'(5)) begin
      errors++; $display("FAIL idle_hold: we=%b addr=%0d need 0/5", vram_we, vram_addr);
    end
  endtask

  task automatic test_contention;
    for (int i = 0; i < 4; i++) begin
      drive(1, 10, 2, 0, 0, 1, 77, 12'h123); #1;
      checks++;
      if (wr_gnt !== 1'b0) begin errors++; $display("FAIL contend_gnt%0d: gnt=%b need 0", i, wr_gnt); end
      tick;
      checks++;
      if (vram_we !== 1'b0) begin errors++; $display("FAIL contend_we%0d: we=%b need 0", i, vram_we); end
    end
    checks++;
    if (wr_stall_cnt !== 16'd4) begin errors++; $display("FAIL stall_cnt: got %0d need 4", wr_stall_cnt); end
    drive(0, 0, 0, 0, 0, 1, 77, 12'h123); #1;
    checks++;
    if (wr_gnt !== 1'b1) begin errors++; $display("FAIL release_gnt: gnt=%b need 1", wr_gnt); end
    tick; idle;
    checks++;
    if (vram_we !== 1'b1 || vram_addr !== AW'(77) || vram_wdata !== 12'h123 || wr_stall_cnt !== 16'd4) begin
      errors++; $display("FAIL release_write: we=%b addr=%0d data=%h stall=%0d need 1/77/123/4",
                         vram_we, vram_addr, vram_wdata, wr_stall_cnt);
    end
    tick; tick; tick;
  endtask

  task automatic test_reset_midflight;
    drive(1, 3, 4, 0, 0, 0, 0, 0); tick;
    drive(1, 4, 4, 0, 0, 0, 0, 0); tick;
    Rst_n = 1'b0; #1;
    checks++;
    if ({vram_addr, vram_we, pix_rgb, pix_vld, scroll_cur, wr_stall_cnt} !== '0) begin
      errors++; $display("FAIL reset_async: addr=%0d we=%b pix=%h vld=%b scroll=%0d stall=%0d need all 0",
                         vram_addr, vram_we, pix_rgb, pix_vld, scroll_cur, wr_stall_cnt);
    end
    idle; tick;
    Rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      checks++;
      if (pix_vld !== 1'b0) begin errors++; $display("FAIL post_reset_vld%0d: vld=%b need 0", i, pix_vld); end
    end
    drive(1, 0, 0, 0, 0, 0, 0, 0); tick; idle;
    for (int i = 1; i <= 3; i++) begin
      checks++;
      if (pix_vld !== (i == 3)) begin errors++; $display("FAIL first_read_t%0d: vld=%b need %0d", i, pix_vld, i == 3); end
      if (i < 3) tick;
    end
    checks++;
    if (pix_rgb !== pat(0)) begin errors++; $display("FAIL first_read_pix: rgb=%h need %h", pix_rgb, pat(0)); end
    tick;
  endtask

  task automatic test_random;
    int m_addr = 0, m_scroll = 0, m_stall = 0, wa = 0, wd = 0, x, y, sc;
    bit m_we = 0, m_prev = 0, pend = 0, dp, vb;
    logic [PW-1:0] m_wdata = '0;
    bit epv [4];
    logic [PW-1:0] epr [4];
    sh[5] = 12'hABC;
    sh[77] = 12'h123;
    for (int k = 0; k < 4; k++) begin epv[k] = 0; epr[k] = '0; end
    idle;
    Rst_n = 1'b0; tick;
    Rst_n = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      checks++;
      if (vram_addr !== AW'(m_addr) || vram_we !== m_we || (m_we && vram_wdata !== m_wdata)) begin
        errors++; $display("FAIL rnd_port cyc%0d: addr=%0d we=%b data=%h need %0d/%b/%h",
                           i, vram_addr, vram_we, vram_wdata, m_addr, m_we, m_wdata);
      end
      checks++;
      if (pix_vld !== epv[i % 4] || pix_rgb !== epr[i % 4]) begin
        errors++; $display("FAIL rnd_pix cyc%0d: vld=%b rgb=%h need %b/%h", i, pix_vld, pix_rgb, epv[i % 4], epr[i % 4]);
      end
      checks++;
      if (wr_stall_cnt !== 16'(m_stall) || scroll_cur !== 10'(m_scroll)) begin
        errors++; $display("FAIL rnd_state cyc%0d: stall=%0d scroll=%0d need %0d/%0d", i, wr_stall_cnt, scroll_cur, m_stall, m_scroll);
      end
      dp = 1'($urandom_range(0, 1));
      x = int'($urandom_range(0, 639));
      y = int'($urandom_range(0, 479));
      sc = int'($urandom_range(0, 1023));
      vb = ($urandom_range(0, 15) == 0) ? !vblank : vblank;
      if (!pend && $urandom_range(0, 2) == 0) begin
        pend = 1;
        wa = int'($urandom_range(0, 1024 * 480 - 1));
        wd = int'($urandom_range(0, 4095));
      end
      drive(dp, x, y, vb, sc, pend, wa, wd);
      #1;
      checks++;
      if (wr_gnt !== (pend && !dp)) begin
        errors++; $display("FAIL rnd_gnt cyc%0d: gnt=%b need %b", i, wr_gnt, pend && !dp);
      end
      epv[(i + 3) % 4] = dp;
      epr[(i + 3) % 4] = '0;
      m_we = 0;
      if (pend && dp && m_stall < 65535) m_stall++;
      if (dp) begin
        m_addr = y * 1024 + (x + m_scroll) % 1024;
        epr[(i + 3) % 4] = sh_rd(m_addr);
      end else if (pend) begin
        m_addr = wa;
        m_we = 1;
        m_wdata = PW'(wd);
        sh[wa] = PW'(wd);
        pend = 0;
      end
      if (vb && !m_prev) m_scroll = sc % 1024;
      m_prev = vb;
      tick;
    end
    idle;
  endtask

  initial begin
    test_reset;
    test_scroll_read;
    test_wrap;
    test_write;
    test_contention;
    test_reset_midflight;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
